// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline run-control sequencer.
package pipeline_sequencer_pkg;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_NOP  = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StFlush,
        StDrain
    } state_e;

    // mov and addi are the only opcodes that read rs and write rd
    function automatic logic op_is_alu(input logic [1:0] op);
        return (op == OP_MOV) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_scoreboard.sv
// EX/WB slot tracking and operand-forwarding select for the instruction in ID.
module hazard_scoreboard
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_advance,
    input  logic              i_clear,
    input  logic              i_id_valid,
    input  logic              i_id_fwd,
    input  logic              i_id_wr,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rd,
    output logic              o_ex_valid,
    output logic              o_wb_valid,
    output logic [1:0]        o_fwd_sel
);

    logic              r_ex_valid;
    logic              r_ex_wr;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_wb_valid;
    logic              r_wb_wr;
    logic [REG_AW-1:0] r_wb_rd;

    // Shift ID -> EX -> WB on advancing cycles; clear wipes both slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_wr    <= 1'b0;
            r_ex_rd    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_wr    <= 1'b0;
            r_wb_rd    <= '0;
        end else if (i_clear) begin
            r_ex_valid <= 1'b0;
            r_ex_wr    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_wr    <= 1'b0;
        end else if (i_advance) begin
            r_ex_valid <= i_id_valid;
            r_ex_wr    <= i_id_valid & i_id_wr;
            r_ex_rd    <= i_id_rd;
            r_wb_valid <= r_ex_valid;
            r_wb_wr    <= r_ex_wr;
            r_wb_rd    <= r_ex_rd;
        end
    end

    // Youngest matching writer wins: EX before WB
    always_comb begin
        o_fwd_sel = FWD_RF;
        if (i_id_fwd) begin
            if (r_ex_valid && r_ex_wr && (i_id_rs == r_ex_rd)) begin
                o_fwd_sel = FWD_EX;
            end else if (r_wb_valid && r_wb_wr && (i_id_rs == r_wb_rd)) begin
                o_fwd_sel = FWD_WB;
            end
        end
    end

    assign o_ex_valid = r_ex_valid;
    assign o_wb_valid = r_wb_valid;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control FSM: start/stop/drain, PC and IF/ID enables, retired counter.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned REG_AW = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    input  logic [1:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rd,
    output logic              pc_en,
    output logic              pc_src,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic [1:0]        fwd_sel,
    output logic              running,
    output logic [CNT_W-1:0]  retired
);

    state_e           r_state;
    state_e           w_state_d;
    logic             r_stop_pend;
    logic             w_stop_pend_d;
    logic [CNT_W-1:0] r_retired;

    logic w_id_valid;
    logic w_stop_req;
    logic w_is_jmp;
    logic w_advance;
    logic w_discard;
    logic w_ex_valid;
    logic w_wb_valid;

    // ID holds a real instruction only in RUN; FILL and FLUSH carry bubbles
    always_comb begin
        w_id_valid = (r_state == StRun);
        w_stop_req = r_stop_pend | stop;
        w_is_jmp   = w_id_valid & (id_opcode == OP_JMP);
        w_advance  = !hold && (r_state != StIdle);
        // A jump caught by a stop is dropped rather than advanced
        w_discard  = w_stop_req & w_is_jmp;
        running    = (r_state == StFill) || (r_state == StRun) || (r_state == StFlush);
    end

    // Next state and pipeline enables; hold suppresses every enable
    always_comb begin
        w_state_d  = r_state;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_d = StFill;
            end
            StFill: begin
                if (!hold) begin
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (!hold) begin
                    ifid_en = 1'b1;
                    if (w_stop_req) begin
                        ifid_flush = 1'b1;
                        w_state_d  = StDrain;
                    end else if (w_is_jmp) begin
                        pc_en      = 1'b1;
                        pc_src     = 1'b1;
                        ifid_flush = 1'b1;
                        w_state_d  = StFlush;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            StFlush: begin
                if (!hold) begin
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    w_state_d = StRun;
                end
            end
            StDrain: begin
                if (!hold && !w_ex_valid) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Sticky stop request: consumed when RUN acts on it, ignored outside a run
    always_comb begin
        w_stop_pend_d = r_stop_pend | stop;
        if ((r_state == StIdle) || (r_state == StDrain)) begin
            w_stop_pend_d = 1'b0;
        end else if ((r_state == StRun) && !hold && w_stop_req) begin
            w_stop_pend_d = 1'b0;
        end
    end

    // State and stop-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_stop_pend <= w_stop_pend_d;
        end
    end

    // Count instructions leaving WB; restart from zero on each start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (r_state == StIdle) begin
            if (start) r_retired <= '0;
        end else if (w_advance && w_wb_valid) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_advance  (w_advance),
        .i_clear    (r_state == StIdle),
        .i_id_valid (w_id_valid & !w_discard),
        .i_id_fwd   (w_id_valid & op_is_alu(id_opcode)),
        .i_id_wr    (op_is_alu(id_opcode)),
        .i_id_rs    (id_rs),
        .i_id_rd    (id_rd),
        .o_ex_valid (w_ex_valid),
        .o_wb_valid (w_wb_valid),
        .o_fwd_sel  (fwd_sel)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed vector bench for pipeline_sequencer (16-bit and 4-bit counter builds).
module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    localparam int NV = 53;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       hold;
    logic [1:0] id_opcode;
    logic [1:0] id_rs;
    logic [1:0] id_rd;

    logic        pc_en, pc_src, ifid_en, ifid_flush, running;
    logic [1:0]  fwd_sel;
    logic [15:0] retired;
    logic        pc_en4, pc_src4, ifid_en4, ifid_flush4, running4;
    logic [1:0]  fwd_sel4;
    logic [3:0]  retired4;

    int n_vec;
    int n_err;

    typedef struct {
        logic [2:0] ctl;   // {start, stop, hold}
        logic [1:0] op;
        logic [1:0] rs;
        logic [1:0] rd;
        state_e     s;
        logic [3:0] en;    // {pc_en, pc_src, ifid_en, ifid_flush}
        logic [1:0] fw;
        int         ret;
    } vec_t;

    vec_t vecs [NV];

    pipeline_sequencer #(.REG_AW(2), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rd(id_rd),
        .pc_en(pc_en), .pc_src(pc_src), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .fwd_sel(fwd_sel), .running(running), .retired(retired)
    );

    pipeline_sequencer #(.REG_AW(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rd(id_rd),
        .pc_en(pc_en4), .pc_src(pc_src4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
        .fwd_sel(fwd_sel4), .running(running4), .retired(retired4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] ctl, input logic [1:0] op,
                                input logic [1:0] rs, input logic [1:0] rd, input state_e s,
                                input logic [3:0] en, input logic [1:0] fw, input int ret);
        vec_t v;
        v.ctl = ctl; v.op = op; v.rs = rs; v.rd = rd;
        v.s = s; v.en = en; v.fw = fw; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input state_e s, input logic [3:0] en,
                           input logic [1:0] fw, input int ret);
        logic run_exp;
        run_exp = (s == StFill) || (s == StRun) || (s == StFlush);
        chk("state",   row, 16'(dut16.r_state), 16'(s));
        chk("enables", row, 16'({pc_en, pc_src, ifid_en, ifid_flush}), 16'(en));
        chk("fwd_sel", row, 16'(fwd_sel), 16'(fw));
        chk("running", row, 16'(running), 16'(run_exp));
        chk("retired", row, retired, 16'(ret));
        chk("ctl4",    row, 16'({pc_en4, pc_src4, ifid_en4, ifid_flush4, fwd_sel4, running4}),
            16'({en, fw, run_exp}));
        chk("retired4", row, 16'(retired4), 16'(ret % 16));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Basic run, forwarding, two jumps, stop with mov in ID
        vecs[0]  = mk(3'b000, OP_NOP,  2'd0, 2'd0, StIdle,  4'b0000, FWD_RF, 0);
        vecs[1]  = mk(3'b000, OP_NOP,  2'd0, 2'd0, StIdle,  4'b0000, FWD_RF, 0);
        vecs[2]  = mk(3'b100, OP_NOP,  2'd0, 2'd0, StIdle,  4'b0000, FWD_RF, 0);
        vecs[3]  = mk(3'b000, OP_NOP,  2'd0, 2'd0, StFill,  4'b1010, FWD_RF, 0);
        vecs[4]  = mk(3'b000, OP_ADDI, 2'd0, 2'd1, StRun,   4'b1010, FWD_RF, 0);
        vecs[5]  = mk(3'b000, OP_MOV,  2'd1, 2'd2, StRun,   4'b1010, FWD_EX, 0);
        vecs[6]  = mk(3'b000, OP_NOP,  2'd0, 2'd0, StRun,   4'b1010, FWD_RF, 0);
        vecs[7]  = mk(3'b000, OP_MOV,  2'd2, 2'd3, StRun,   4'b1010, FWD_WB, 1);
        vecs[8]  = mk(3'b000, OP_ADDI, 2'd0, 2'd1, StRun,   4'b1010, FWD_RF, 2);
        vecs[9]  = mk(3'b000, OP_ADDI, 2'd3, 2'd1, StRun,   4'b1010, FWD_WB, 3);
        vecs[10] = mk(3'b000, OP_MOV,  2'd1, 2'd2, StRun,   4'b1010, FWD_EX, 4);
        vecs[11] = mk(3'b000, OP_JMP,  2'd2, 2'd0, StRun,   4'b1111, FWD_RF, 5);
        vecs[12] = mk(3'b000, OP_MOV,  2'd2, 2'd0, StFlush, 4'b1010, FWD_RF, 6);
        vecs[13] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StRun,   4'b1010, FWD_RF, 7);
        vecs[14] = mk(3'b000, OP_JMP,  2'd0, 2'd0, StRun,   4'b1111, FWD_RF, 8);
        vecs[15] = mk(3'b000, OP_JMP,  2'd0, 2'd0, StFlush, 4'b1010, FWD_RF, 8);
        vecs[16] = mk(3'b000, OP_MOV,  2'd0, 2'd2, StRun,   4'b1010, FWD_RF, 9);
        vecs[17] = mk(3'b010, OP_MOV,  2'd2, 2'd3, StRun,   4'b0011, FWD_EX, 10);
        vecs[18] = mk(3'b000, OP_MOV,  2'd3, 2'd0, StDrain, 4'b0000, FWD_RF, 10);
        vecs[19] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StDrain, 4'b0000, FWD_RF, 11);
        vecs[20] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StIdle,  4'b0000, FWD_RF, 12);
        // Restart, hold with stop pulsed inside it, stop beating a jump
        vecs[21] = mk(3'b100, OP_NOP,  2'd0, 2'd0, StIdle,  4'b0000, FWD_RF, 12);
        vecs[22] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StFill,  4'b1010, FWD_RF, 0);
        vecs[23] = mk(3'b000, OP_ADDI, 2'd0, 2'd1, StRun,   4'b1010, FWD_RF, 0);
        vecs[24] = mk(3'b000, OP_MOV,  2'd1, 2'd0, StRun,   4'b1010, FWD_EX, 0);
        vecs[25] = mk(3'b001, OP_JMP,  2'd1, 2'd0, StRun,   4'b0000, FWD_RF, 0);
        vecs[26] = mk(3'b011, OP_JMP,  2'd1, 2'd0, StRun,   4'b0000, FWD_RF, 0);
        vecs[27] = mk(3'b001, OP_JMP,  2'd1, 2'd0, StRun,   4'b0000, FWD_RF, 0);
        vecs[28] = mk(3'b000, OP_JMP,  2'd1, 2'd0, StRun,   4'b0011, FWD_RF, 0);
        vecs[29] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StDrain, 4'b0000, FWD_RF, 1);
        vecs[30] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StIdle,  4'b0000, FWD_RF, 2);
        // Long nop stream: the 4-bit counter wraps 15 -> 0 -> 1
        vecs[31] = mk(3'b100, OP_NOP,  2'd0, 2'd0, StIdle,  4'b0000, FWD_RF, 2);
        vecs[32] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StFill,  4'b1010, FWD_RF, 0);
        for (int c = 33; c <= 49; c++) begin
            vecs[c] = mk(3'b000, OP_NOP, 2'd0, 2'd0, StRun, 4'b1010, FWD_RF,
                         (c > 35) ? c - 35 : 0);
        end
        vecs[50] = mk(3'b010, OP_NOP,  2'd0, 2'd0, StRun,   4'b0011, FWD_RF, 15);
        vecs[51] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StDrain, 4'b0000, FWD_RF, 16);
        vecs[52] = mk(3'b000, OP_NOP,  2'd0, 2'd0, StDrain, 4'b0000, FWD_RF, 17);

        // Reset state, including a start held during reset across a clock edge
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; hold = 1'b0;
        id_opcode = OP_MOV; id_rs = 2'd0; id_rd = 2'd0;
        #3;
        chk_all(-1, StIdle, 4'b0000, FWD_RF, 0);
        @(posedge clk);
        #1;
        chk_all(-2, StIdle, 4'b0000, FWD_RF, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            {start, stop, hold} = vecs[i].ctl;
            id_opcode = vecs[i].op;
            id_rs     = vecs[i].rs;
            id_rd     = vecs[i].rd;
            #1;
            chk_all(i, vecs[i].s, vecs[i].en, vecs[i].fw, vecs[i].ret);
        end

        // Asynchronous reset in the middle of DRAIN clears everything at once
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(100, StIdle, 4'b0000, FWD_RF, 0);

        // Restart after reset: FILL then RUN with the PC enabled
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        #1;
        chk_all(101, StIdle, 4'b0000, FWD_RF, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk_all(102, StFill, 4'b1010, FWD_RF, 0);
        @(negedge clk);
        #1;
        chk_all(103, StRun, 4'b1010, FWD_RF, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run-control and hazard sequencer for the 2-bit-opcode pipeline (IF → ID → EX → WB). It starts, stops and drains the pipeline, and it generates the PC and IF/ID register enables and flushes. It tracks the destination registers of instructions in EX and WB and drives the operand-forwarding select for the instruction in ID. It sits beside the decode control unit: the control unit decodes the opcode, and this block decides when the pipeline advances.

## Interface
Parameters:
- REG_AW, 2: register-address width
- CNT_W, 16: retired-instruction counter width

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins execution from IDLE, ignored in all other states
- stop  in  1  pulse; requests drain to IDLE, captured into a sticky pending flag
- hold  in  1  external stall level; freezes the whole pipeline
- id_opcode  in  2  opcode in ID: 00 mov, 01 addi, 10 nop, 11 jump
- id_rs  in  REG_AW  source register in ID
- id_rd  in  REG_AW  destination register in ID
- pc_en  out  1  PC update enable
- pc_src  out  1  1 selects the jump target
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID register loads a bubble
- fwd_sel  out  2  00 regfile, 01 EX result, 10 WB result
- running  out  1  high in FILL, RUN and FLUSH
- retired  out  CNT_W  count of instructions completing WB

## Operation
- Internal tracking slots: ID valid, EX {valid, rd, wr}, WB {valid, rd, wr}. wr = 1 for opcodes 00 and 01.
- On each advancing cycle (not hold): ID slot → EX slot → WB slot.
- States:
  - IDLE: pc_en = 0, all slots invalid. start → FILL; retired clears to 0.
  - FILL: pc_en = 1, ifid_en = 1, ID valid set. Moves to RUN next cycle (1 cycle).
  - RUN: pc_en = 1, ifid_en = 1 when not hold.
    - Jump (id_opcode = 11, ID valid): pc_src = 1 and ifid_flush = 1 in the same cycle; → FLUSH. The jump itself advances as a non-writer.
    - stop pending: ifid_flush = 1, pc_en = 0; the ID instruction advances; → DRAIN.
  - FLUSH: ID slot treated invalid (no jump detection, no forwarding, bubble advances), pc_en = 1, ifid_en = 1; → RUN.
  - DRAIN: pc_en = 0, ifid_en = 0, ID invalid. When EX valid = 0 → IDLE.
- hold: in any non-IDLE state, pc_en, ifid_en and ifid_flush are 0, slots and state are frozen, and retired does not count. hold takes priority over stop and jump.
- stop together with a jump in the same cycle: stop wins. The jump is discarded (it does not advance) and pc_src = 0.
- Forwarding (only when ID is valid and id_opcode ∈ {00, 01}):
  - id_rs == EX.rd with EX valid & wr → 01.
  - else id_rs == WB.rd with WB valid & wr → 10.
  - else 00.
  - EX has priority over WB.
- retired increments by 1 for each WB-valid, non-bubble slot on a non-hold cycle, including nop and jump. It wraps from 2^CNT_W−1 to 0.
- Reset mid-operation: everything returns immediately to the reset state; the stop flag clears.

## Timing
- Reset values:
  - state IDLE, all slots invalid, stop flag 0.
  - pc_en, pc_src, ifid_en, ifid_flush, running = 0; fwd_sel = 00; retired = 0.
- Registered: state, slots, stop flag, retired.
- Combinational from state, slots and inputs: pc_en, pc_src, ifid_en, ifid_flush, fwd_sel.
- start at cycle t: FILL and pc_en = 1 at t+1; RUN at t+2.
- Jump in ID at cycle t: pc_src and ifid_flush at t; FLUSH at t+1; RUN at t+2.
- stop acting at cycle t: DRAIN at t+1 and t+2; IDLE at t+3. The final instruction retires at t+2.
- A stop pulse during hold is acted on in the first non-hold cycle.

## Structure
- Shared package holds:
  - opcode constants OP_MOV = 2'b00, OP_ADDI = 2'b01, OP_NOP = 2'b10, OP_JMP = 2'b11
  - state encoding IDLE/FILL/RUN/FLUSH/DRAIN
  - forwarding encodings FWD_RF/FWD_EX/FWD_WB
- One sub-module, hazard_scoreboard, holds the EX/WB slot tracking and produces fwd_sel. The FSM, counter and enables stay in pipeline_sequencer.

## Test plan
- Reset then start at cycle 2 → pc_en = 1 from cycle 3, FILL in cycle 3, RUN in cycle 4, retired = 0.
- ID: addi rd = 1, then mov rs = 1 next cycle → fwd_sel = 01. With a nop between them → fwd_sel = 10. With rd = 1 in both EX and WB → 01.
- Jump in ID at RUN cycle 10 → pc_src = 1 and ifid_flush = 1 at cycle 10; FLUSH at 11; no forwarding or jump detection at 11; RUN at 12.
- Stop at cycle 20 with mov in ID → DRAIN at 21 and 22, IDLE at 23. retired rises by 1 at cycle 22; pc_en = 0 from cycle 20.
- hold high during cycles 30–32 with stop pulsed at 31 → outputs frozen and retired unchanged; DRAIN entered at 34.
- CNT_W = 4, run 17 nops → retired wraps from 15 to 0, then reads 1. Deassert rst_n mid-DRAIN → all outputs 0 immediately.
